// File: rtl/axil_interconnect_pkg.sv
// Shared types for the AXI-Lite priority interconnect arbiters.
package axil_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_arb_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_arb_state_t;

endpackage

// File: rtl/axil_arbiter_priority_wr_if.sv
// Request/handshake/grant bundle between the write arbiter and the write-path muxes.
interface axil_arbiter_priority_wr_if #(
  parameter int unsigned NUMBER_MASTER = 20
);
  localparam int unsigned IDX_W = $clog2(NUMBER_MASTER);

  logic [NUMBER_MASTER-1:0] request_wr;
  logic [NUMBER_MASTER-1:0] m_axil_awvalid;
  logic [NUMBER_MASTER-1:0] m_axil_wvalid;
  logic [NUMBER_MASTER-1:0] m_axil_bready;
  logic                     s_axil_awready;
  logic                     s_axil_wready;
  logic                     s_axil_bvalid;
  logic [NUMBER_MASTER-1:0] grant_wr;
  logic [IDX_W-1:0]         grant_wr_idx;
  logic                     aw_en;
  logic                     w_en;
  logic                     b_en;

  // Arbiter side.
  modport slave (
    input  request_wr, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
    input  s_axil_awready, s_axil_wready, s_axil_bvalid,
    output grant_wr, grant_wr_idx, aw_en, w_en, b_en
  );

  // Requester / fabric side.
  modport master (
    output request_wr, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
    output s_axil_awready, s_axil_wready, s_axil_bvalid,
    input  grant_wr, grant_wr_idx, aw_en, w_en, b_en
  );

endinterface

// File: rtl/axil_priority_encoder.sv
// Lowest-index-wins priority encoder: one-hot grant plus encoded index (both 0 when no request).
module axil_priority_encoder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int unsigned IDX_W = $clog2(N);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/axil_arbiter_priority_wr.sv
// Fixed-priority AXI-Lite write arbiter: holds one master from AW/W through the B handshake.
module axil_arbiter_priority_wr
  import axil_interconnect_pkg::*;
#(
  parameter int unsigned NUMBER_MASTER = 20
) (
  input logic                       aclk,
  input logic                       aresetn,
  axil_arbiter_priority_wr_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUMBER_MASTER);

  wr_arb_state_t            r_state, w_state_d;
  logic [NUMBER_MASTER-1:0] r_grant, w_grant_d, w_next_grant;
  logic [IDX_W-1:0]         r_idx, w_idx_d, w_next_idx;
  logic                     r_aw_done, w_aw_done_d, r_w_done, w_w_done_d;
  logic                     w_aw_en, w_w_en, w_b_en, w_aw_hs, w_w_hs;

  axil_priority_encoder #(
    .N (NUMBER_MASTER)
  ) u_enc (
    .i_req   (bus.request_wr),
    .o_grant (w_next_grant),
    .o_idx   (w_next_idx)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_grant   <= w_grant_d;
      r_idx     <= w_idx_d;
      r_aw_done <= w_aw_done_d;
      r_w_done  <= w_w_done_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_grant_d   = r_grant;
    w_idx_d     = r_idx;
    w_aw_done_d = r_aw_done;
    w_w_done_d  = r_w_done;
    w_aw_en     = 1'b0;
    w_w_en      = 1'b0;
    w_b_en      = 1'b0;
    w_aw_hs     = 1'b0;
    w_w_hs      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|bus.request_wr) begin
          w_state_d   = DATA;
          w_grant_d   = w_next_grant;
          w_idx_d     = w_next_idx;
          w_aw_done_d = 1'b0;
          w_w_done_d  = 1'b0;
        end
      end
      DATA: begin
        // Each channel closes once done so the master cannot issue a second beat.
        w_aw_en = !r_aw_done;
        w_w_en  = !r_w_done;
        w_aw_hs = w_aw_en & bus.m_axil_awvalid[r_idx] & bus.s_axil_awready;
        w_w_hs  = w_w_en & bus.m_axil_wvalid[r_idx] & bus.s_axil_wready;
        if (w_aw_hs) w_aw_done_d = 1'b1;
        if (w_w_hs)  w_w_done_d  = 1'b1;
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_state_d = RESP;
      end
      RESP: begin
        w_b_en = 1'b1;
        if (bus.s_axil_bvalid & bus.m_axil_bready[r_idx]) begin
          w_state_d   = IDLE;
          w_grant_d   = '0;
          w_idx_d     = '0;
          w_aw_done_d = 1'b0;
          w_w_done_d  = 1'b0;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign bus.grant_wr     = r_grant;
  assign bus.grant_wr_idx = r_idx;
  assign bus.aw_en        = w_aw_en;
  assign bus.w_en         = w_w_en;
  assign bus.b_en         = w_b_en;

  a_grant_onehot0: assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0(r_grant));
  a_grant_matches_idx: assert property (@(posedge aclk) disable iff (!aresetn)
    (r_state != IDLE) |-> r_grant[r_idx]);
  a_enables_exclusive: assert property (@(posedge aclk) disable iff (!aresetn)
    !(w_b_en & (w_aw_en | w_w_en)));

endmodule

// File: tb/tb_axil_arbiter_priority_wr.sv
// Self-checking bench for axil_arbiter_priority_wr with four masters.
module tb_axil_arbiter_priority_wr;
  localparam int unsigned N = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [8:0] obs, exp;

  always #5 aclk = ~aclk;

  axil_arbiter_priority_wr_if #(.NUMBER_MASTER(N)) bus ();

  axil_arbiter_priority_wr #(
    .NUMBER_MASTER (N)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  assign obs = {bus.grant_wr, bus.grant_wr_idx, bus.aw_en, bus.w_en, bus.b_en};

  function automatic logic [8:0] pk(logic [3:0] g, int idx, bit a, bit w, bit b);
    return {g, 2'(idx), a, w, b};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clr();
    bus.request_wr     = '0;
    bus.m_axil_awvalid = '0;
    bus.m_axil_wvalid  = '0;
    bus.m_axil_bready  = '0;
    bus.s_axil_awready = 1'b0;
    bus.s_axil_wready  = 1'b0;
    bus.s_axil_bvalid  = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    exp = '0;
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_state got=%b exp=%b", obs, exp); end
    tick();
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL idle_hold got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_single();
    do_reset();
    bus.request_wr = 4'b0100;
    tick();
    exp = pk(4'b0100, 2, 1, 1, 0);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL single_grant got=%b exp=%b", obs, exp); end
    bus.m_axil_awvalid = 4'b0100; bus.s_axil_awready = 1'b1;
    tick();
    exp = pk(4'b0100, 2, 0, 1, 0);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL single_aw got=%b exp=%b", obs, exp); end
    bus.m_axil_awvalid = '0;
    bus.m_axil_wvalid = 4'b0100; bus.s_axil_wready = 1'b1;
    tick();
    exp = pk(4'b0100, 2, 0, 0, 1);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL single_resp got=%b exp=%b", obs, exp); end
    bus.m_axil_wvalid = '0; bus.request_wr = '0;
    bus.s_axil_bvalid = 1'b1; bus.m_axil_bready = 4'b0100;
    tick();
    exp = '0;
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL single_release got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.request_wr = 4'b1010;
    tick();
    exp = pk(4'b0010, 1, 1, 1, 0);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL simul_grant got=%b exp=%b", obs, exp); end
    // AW and W together, slave B valid early must be ignored in DATA.
    bus.m_axil_awvalid = 4'b0010; bus.m_axil_wvalid = 4'b0010;
    bus.s_axil_awready = 1'b1; bus.s_axil_wready = 1'b1;
    bus.s_axil_bvalid = 1'b1; bus.m_axil_bready = 4'b1111;
    tick();
    exp = pk(4'b0010, 1, 0, 0, 1);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL simul_both_hs got=%b exp=%b", obs, exp); end
    bus.m_axil_awvalid = '0; bus.m_axil_wvalid = '0;
    bus.request_wr = 4'b1000;
    tick();
    exp = '0;
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL simul_idle got=%b exp=%b", obs, exp); end
    bus.s_axil_bvalid = 1'b0;
    tick();
    exp = pk(4'b1000, 3, 1, 1, 0);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL simul_regrant got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_ordering();
    for (int o = 0; o < 2; o++) begin
      do_reset();
      bus.request_wr = 4'b0001;
      tick();
      bus.request_wr = '0;
      exp = pk(4'b0001, 0, 1, 1, 0);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL order%0d_grant got=%b exp=%b", o, obs, exp); end
      tick();
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL order%0d_wait got=%b exp=%b", o, obs, exp); end
      if (o == 0) begin bus.m_axil_wvalid = 4'b0001; bus.s_axil_wready = 1'b1; end
      else begin bus.m_axil_awvalid = 4'b0001; bus.s_axil_awready = 1'b1; end
      tick();
      exp = (o == 0) ? pk(4'b0001, 0, 1, 0, 0) : pk(4'b0001, 0, 0, 1, 0);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL order%0d_first got=%b exp=%b", o, obs, exp); end
      tick();
      tick();
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL order%0d_block got=%b exp=%b", o, obs, exp); end
      if (o == 0) begin bus.m_axil_awvalid = 4'b0001; bus.s_axil_awready = 1'b1; end
      else begin bus.m_axil_wvalid = 4'b0001; bus.s_axil_wready = 1'b1; end
      tick();
      exp = pk(4'b0001, 0, 0, 0, 1);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL order%0d_resp got=%b exp=%b", o, obs, exp); end
    end
  endtask

  task automatic test_b_backpressure();
    do_reset();
    bus.request_wr = 4'b0100;
    tick();
    bus.m_axil_awvalid = 4'b0100; bus.m_axil_wvalid = 4'b0100;
    bus.s_axil_awready = 1'b1; bus.s_axil_wready = 1'b1;
    tick();
    bus.m_axil_awvalid = '0; bus.m_axil_wvalid = '0;
    bus.s_axil_bvalid = 1'b1; bus.m_axil_bready = 4'b1011;
    exp = pk(4'b0100, 2, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL bp_hold%0d got=%b exp=%b", i, obs, exp); end
    end
    bus.m_axil_bready = 4'b0100; bus.request_wr = '0;
    tick();
    exp = '0;
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL bp_release got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_no_preempt();
    do_reset();
    bus.request_wr = 4'b0100;
    tick();
    bus.request_wr = 4'b0101;
    tick();
    exp = pk(4'b0100, 2, 1, 1, 0);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL nopre_data got=%b exp=%b", obs, exp); end
    bus.m_axil_awvalid = 4'b0101; bus.m_axil_wvalid = 4'b0101;
    bus.s_axil_awready = 1'b1; bus.s_axil_wready = 1'b1;
    tick();
    exp = pk(4'b0100, 2, 0, 0, 1);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL nopre_resp got=%b exp=%b", obs, exp); end
    bus.m_axil_awvalid = '0; bus.m_axil_wvalid = '0;
    bus.s_axil_bvalid = 1'b1; bus.m_axil_bready = 4'b0100;
    bus.request_wr = 4'b0001;
    tick();
    bus.s_axil_bvalid = 1'b0;
    exp = '0;
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL nopre_idle got=%b exp=%b", obs, exp); end
    tick();
    exp = pk(4'b0001, 0, 1, 1, 0);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL nopre_next got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.request_wr = 4'b0010;
    tick();
    bus.m_axil_awvalid = 4'b0010; bus.m_axil_wvalid = 4'b0010;
    bus.s_axil_awready = 1'b1; bus.s_axil_wready = 1'b1;
    tick();
    bus.m_axil_awvalid = '0; bus.m_axil_wvalid = '0;
    aresetn = 1'b0;
    tick();
    exp = '0;
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL rstmid_clear got=%b exp=%b", obs, exp); end
    aresetn = 1'b1;
    tick();
    exp = pk(4'b0010, 1, 1, 1, 0);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL rstmid_regrant got=%b exp=%b", obs, exp); end
  endtask

  // Transaction-level reference: owner of the write path and which phases it has completed.
  task automatic test_random();
    int owner;
    bit got_aw, got_w, in_resp, aw_fire, w_fire;
    logic [3:0] g;
    do_reset();
    owner = -1; got_aw = 0; got_w = 0; in_resp = 0;
    for (int c = 0; c < 400; c++) begin
      bus.request_wr     = 4'($urandom);
      bus.m_axil_awvalid = 4'($urandom);
      bus.m_axil_wvalid  = 4'($urandom);
      bus.m_axil_bready  = 4'($urandom);
      bus.s_axil_awready = 1'($urandom_range(0, 1));
      bus.s_axil_wready  = 1'($urandom_range(0, 1));
      bus.s_axil_bvalid  = 1'($urandom_range(0, 1));
      aresetn            = ($urandom_range(0, 39) != 0);
      if (!aresetn) begin
        owner = -1; got_aw = 0; got_w = 0; in_resp = 0;
      end else if (owner < 0) begin
        for (int i = 0; i < int'(N); i++) begin
          if (bus.request_wr[i]) begin owner = i; break; end
        end
        got_aw = 0; got_w = 0; in_resp = 0;
      end else if (!in_resp) begin
        aw_fire = !got_aw && bus.m_axil_awvalid[owner] && bus.s_axil_awready;
        w_fire  = !got_w && bus.m_axil_wvalid[owner] && bus.s_axil_wready;
        got_aw  = got_aw || aw_fire;
        got_w   = got_w || w_fire;
        in_resp = got_aw && got_w;
      end else if (bus.s_axil_bvalid && bus.m_axil_bready[owner]) begin
        owner = -1; got_aw = 0; got_w = 0; in_resp = 0;
      end
      tick();
      if (owner < 0) exp = '0;
      else begin
        g = '0;
        g[owner] = 1'b1;
        exp = pk(g, owner, !in_resp && !got_aw, !in_resp && !got_w, in_resp);
      end
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random_c%0d got=%b exp=%b", c, obs, exp);
      end
    end
    aresetn = 1'b1;
  endtask

  initial begin
    clr();
    test_reset();
    test_single();
    test_simultaneous();
    test_ordering();
    test_b_backpressure();
    test_no_preempt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
